// File: rtl/hazard_controller_pkg.sv
// Shared pipeline hazard definitions: FSM state encoding, stall/flush select constants, load-use helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hazard_controller_pkg;

    localparam int MD_CNT_W = 6;   // wide enough for MD_CYCLES up to 63

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MD_RUN   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    // Stall/flush select bundle driven to the pipeline registers.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0,
                                       stall_m: 1'b0, flush_d: 1'b0, flush_e: 1'b0};
    // Data memory not ready: freeze the whole pipe.
    localparam hz_ctrl_t CTRL_STALL_ALL = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                            stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0};
    // Mul/div in E: hold F/D/E, let M drain.
    localparam hz_ctrl_t CTRL_MD = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                     stall_m: 1'b0, flush_d: 1'b0, flush_e: 1'b0};
    // Taken branch in E: kill the two younger instructions.
    localparam hz_ctrl_t CTRL_BRANCH = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0,
                                         stall_m: 1'b0, flush_d: 1'b1, flush_e: 1'b1};
    // Load-use: hold F/D, inject one bubble into E.
    localparam hz_ctrl_t CTRL_LOAD_USE = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b0,
                                           stall_m: 1'b0, flush_d: 1'b0, flush_e: 1'b1};

    // A load writing x0 never produces a usable value, so it never stalls.
    function automatic logic load_use(
        input logic       mem_rd,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used
    );
        return mem_rd && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_controller_md_counter.sv
// Mul/div occupancy counter: load, decrement to zero, or freeze; exposes a zero flag.
// Latency: count updates on the next rising edge; o_zero is combinational from the count.
// Backpressure: holds its value whenever neither load nor decrement is asserted.
// Ports: clk/rst (sync, active-high), i_load + i_load_val, i_dec, o_zero.
module md_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle mul/div hold, data-memory wait.
// Latency: stall/flush are combinational from state+inputs; md_start/md_busy are registered (state only).
// Backpressure: dmem_ready=0 with M_mem_req freezes all stages and the mul/div counter.
// Ports: clk, rst; D_E_* / F_D_* hazard sources; E_branch_taken, E_md_valid; M_mem_req, dmem_ready;
//        stall_F/D/E/M, flush_D/E, md_start, md_busy.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D_E_mem_rd,
    input  logic [4:0] D_E_rd_index,
    input  logic [4:0] F_D_rs1_index,
    input  logic [4:0] F_D_rs2_index,
    input  logic       F_D_rs1_used,
    input  logic       F_D_rs2_used,
    input  logic       E_branch_taken,
    input  logic       E_md_valid,
    input  logic       M_mem_req,
    input  logic       dmem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       flush_D,
    output logic       flush_E,
    output logic       md_start,
    output logic       md_busy
);

    // The launch cycle is itself a held cycle, so the counter starts one short.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

    hz_state_e r_state;
    hz_state_e r_saved;
    logic      r_md_start;
    logic      r_md_busy;

    hz_state_e w_eff_state;
    hz_state_e w_next_state;
    hz_state_e w_next_saved;
    hz_ctrl_t  w_ctrl;
    logic      w_mem_wait;
    logic      w_lu;
    logic      w_cnt_load;
    logic      w_cnt_dec;
    logic      w_cnt_zero;
    logic      w_launch;

    assign w_mem_wait = M_mem_req && !dmem_ready;
    assign w_lu       = load_use(D_E_mem_rd, D_E_rd_index, F_D_rs1_index, F_D_rs2_index,
                                 F_D_rs1_used, F_D_rs2_used);

    // MEM_WAIT is a wrapper around the interrupted state: once memory is ready
    // the cycle behaves exactly as the saved state would.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_saved : r_state;

    always_comb begin
        w_ctrl       = CTRL_NONE;
        w_next_state = w_eff_state;
        w_next_saved = r_saved;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_launch     = 1'b0;
        if (w_mem_wait) begin
            w_ctrl       = CTRL_STALL_ALL;
            w_next_state = ST_MEM_WAIT;
            w_next_saved = w_eff_state;
        end else if (w_eff_state == ST_MD_RUN) begin
            // Final cycle releases the stalls so the result leaves E next edge.
            if (w_cnt_zero) begin
                w_next_state = ST_IDLE;
            end else begin
                w_ctrl    = CTRL_MD;
                w_cnt_dec = 1'b1;
            end
        end else if (E_md_valid) begin
            // Mul/div beats a simultaneous branch.
            w_ctrl       = CTRL_MD;
            w_cnt_load   = 1'b1;
            w_launch     = 1'b1;
            w_next_state = ST_MD_RUN;
        end else if (E_branch_taken) begin
            w_ctrl = CTRL_BRANCH;
        end else if (w_lu) begin
            w_ctrl = CTRL_LOAD_USE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_saved    <= ST_IDLE;
            r_md_start <= 1'b0;
            r_md_busy  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_saved    <= w_next_saved;
            r_md_start <= w_launch;
            r_md_busy  <= (w_next_state == ST_MD_RUN) ||
                          ((w_next_state == ST_MEM_WAIT) && (w_next_saved == ST_MD_RUN));
        end
    end

    md_counter #(
        .W (MD_CNT_W)
    ) u_md_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (MD_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign stall_F  = w_ctrl.stall_f;
    assign stall_D  = w_ctrl.stall_d;
    assign stall_E  = w_ctrl.stall_e;
    assign stall_M  = w_ctrl.stall_m;
    assign flush_D  = w_ctrl.flush_d;
    assign flush_E  = w_ctrl.flush_e;
    assign md_start = r_md_start;
    assign md_busy  = r_md_busy;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic against a cycle model.
// Latency: one comparison per clock, sampled on the falling edge.
// Backpressure: random dmem_ready drops exercise the memory-wait path.
module tb_hazard_controller;

    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       D_E_mem_rd;
    logic [4:0] D_E_rd_index;
    logic [4:0] F_D_rs1_index;
    logic [4:0] F_D_rs2_index;
    logic       F_D_rs1_used;
    logic       F_D_rs2_used;
    logic       E_branch_taken;
    logic       E_md_valid;
    logic       M_mem_req;
    logic       dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, md_start, md_busy;

    always #5 clk = ~clk;

    hazard_controller #(.MD_CYCLES(MDC)) dut (
        .clk            (clk),
        .rst            (rst),
        .D_E_mem_rd     (D_E_mem_rd),
        .D_E_rd_index   (D_E_rd_index),
        .F_D_rs1_index  (F_D_rs1_index),
        .F_D_rs2_index  (F_D_rs2_index),
        .F_D_rs1_used   (F_D_rs1_used),
        .F_D_rs2_used   (F_D_rs2_used),
        .E_branch_taken (E_branch_taken),
        .E_md_valid     (E_md_valid),
        .M_mem_req      (M_mem_req),
        .dmem_ready     (dmem_ready),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .stall_E        (stall_E),
        .stall_M        (stall_M),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .md_start       (md_start),
        .md_busy        (md_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: cycles of mul/div sequence still to run (0 = none), and a
    // pending start pulse owed for the cycle after a launch.
    int md_left    = 0;
    bit start_pend = 1'b0;

    // Observed stall_E / md_busy / md_start cycles, for occupancy checks.
    int cnt_stall_e = 0;
    int cnt_busy    = 0;
    int cnt_start   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        D_E_mem_rd     = 1'b0;
        D_E_rd_index   = 5'd0;
        F_D_rs1_index  = 5'd0;
        F_D_rs2_index  = 5'd0;
        F_D_rs1_used   = 1'b0;
        F_D_rs2_used   = 1'b0;
        E_branch_taken = 1'b0;
        E_md_valid     = 1'b0;
        M_mem_req      = 1'b0;
        dmem_ready     = 1'b1;
    endtask

    // Inputs are already driven; compare at the falling edge, then advance the model over the rising edge.
    task automatic cycle(input string tag);
        bit         waiting;
        bit         lu;
        bit         launch;
        int         md_left_n;
        logic [5:0] ctl;   // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
        logic [7:0] exp_v;
        @(negedge clk);
        waiting   = M_mem_req && !dmem_ready;
        lu        = D_E_mem_rd && (D_E_rd_index != 0) &&
                    ((F_D_rs1_used && F_D_rs1_index == D_E_rd_index) ||
                     (F_D_rs2_used && F_D_rs2_index == D_E_rd_index));
        launch    = 1'b0;
        md_left_n = md_left;
        ctl       = 6'b000000;
        if (waiting) begin
            ctl = 6'b111100;
        end else if (md_left > 0) begin
            if (md_left > 1) ctl = 6'b111000;
            md_left_n = md_left - 1;
        end else if (E_md_valid) begin
            ctl       = 6'b111000;
            launch    = 1'b1;
            md_left_n = MDC;
        end else if (E_branch_taken) begin
            ctl = 6'b000011;
        end else if (lu) begin
            ctl = 6'b110001;
        end
        exp_v = {ctl, start_pend, (md_left > 0)};
        check(tag, {24'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, md_start, md_busy},
              {24'd0, exp_v});
        if (stall_E) cnt_stall_e++;
        if (md_busy) cnt_busy++;
        if (md_start) cnt_start++;
        @(posedge clk);
        if (rst) begin
            md_left    = 0;
            start_pend = 1'b0;
        end else begin
            md_left    = md_left_n;
            start_pend = launch;
        end
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        cycle("reset_hold");
        rst = 1'b0;
        cycle("after_reset");

        // Load x5 in E, D reads x5 via rs2: one bubble, then the load has moved on.
        D_E_mem_rd = 1'b1; D_E_rd_index = 5'd5;
        F_D_rs2_index = 5'd5; F_D_rs2_used = 1'b1;
        cycle("lu_x5");
        D_E_mem_rd = 1'b0;
        cycle("lu_x5_after");

        // Load x0 feeding x0: never a hazard.
        D_E_mem_rd = 1'b1; D_E_rd_index = 5'd0;
        F_D_rs1_index = 5'd0; F_D_rs1_used = 1'b1;
        F_D_rs2_index = 5'd0;
        cycle("lu_x0");

        // Branch together with a load-use hazard: branch wins.
        D_E_rd_index = 5'd7; F_D_rs1_index = 5'd7;
        E_branch_taken = 1'b1;
        cycle("br_over_lu");
        idle_inputs();

        // Mul/div occupancy: md instruction sits in E until released.
        cnt_stall_e = 0; cnt_busy = 0; cnt_start = 0;
        E_md_valid = 1'b1;
        for (int i = 0; i < MDC + 1; i++) cycle("md_seq");
        E_md_valid = 1'b0;
        cycle("md_done");
        check("md_stall_e_cycles", cnt_stall_e, MDC);
        check("md_busy_cycles", cnt_busy, MDC);
        check("md_start_pulses", cnt_start, 1);

        // Memory wait in the middle of a mul/div run (launch, c=3, then wait at c=2).
        E_md_valid = 1'b1;
        cycle("mdw_launch");
        cycle("mdw_run");
        M_mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mdw_wait");
        dmem_ready = 1'b1;
        cnt_stall_e = 0;
        cycle("mdw_ready");
        M_mem_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mdw_resume");
        E_md_valid = 1'b0;
        check("mdw_resume_stalls", cnt_stall_e, 3);

        // Reset pulse mid-run aborts without a second start.
        E_md_valid = 1'b1;
        cycle("rst_launch");
        cycle("rst_run");
        idle_inputs();
        rst = 1'b1;
        cycle("rst_pulse");
        rst = 1'b0;
        cnt_start = 0;
        cycle("rst_after");
        cycle("rst_after2");
        check("rst_no_start", cnt_start, 0);

        // Randomized traffic biased towards collisions.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            D_E_mem_rd     = ($urandom_range(0, 2) == 0);
            D_E_rd_index   = 5'($urandom_range(0, 3));
            F_D_rs1_index  = 5'($urandom_range(0, 3));
            F_D_rs2_index  = 5'($urandom_range(0, 3));
            F_D_rs1_used   = $urandom_range(0, 1) != 0;
            F_D_rs2_used   = $urandom_range(0, 1) != 0;
            E_branch_taken = ($urandom_range(0, 5) == 0);
            E_md_valid     = ($urandom_range(0, 11) == 0);
            M_mem_req      = ($urandom_range(0, 2) == 0);
            dmem_ready     = ($urandom_range(0, 2) != 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
